// File: rtl/count_mon_pkg.sv
// Shared constants for count_monitor: default widths and FSM state encodings.
package count_mon_pkg;

  localparam int unsigned CW_DEF  = 3;
  localparam int unsigned EW_DEF  = 8;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_WAIT  = 2'd0;
  localparam logic [STATE_W-1:0] ST_TRACK = 2'd1;
  localparam logic [STATE_W-1:0] ST_FAULT = 2'd2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a W-bit bus, cleared by the synchronous reset.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/count_monitor.sv
// Monitors an asynchronous up counter: synchronizes, filters ripple, checks +1 steps.
// Optional saturating error counter enabled by defining ERRCNT_EN.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned EW = EW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] count_in,
  input  logic          cnt_reset_in,
  output logic [CW-1:0] count_sync,
  output logic          step,
  output logic          wrap,
  output logic          err,
  output logic          fault,
  output logic [EW-1:0] err_cnt
);

  logic [CW-1:0] count_s2;
  logic          crst_s2;

  sync_2ff #(.W(CW)) u_sync_count (
    .clk   (clk),
    .reset (reset),
    .d     (count_in),
    .q     (count_s2)
  );

  sync_2ff #(.W(1)) u_sync_crst (
    .clk   (clk),
    .reset (reset),
    .d     (cnt_reset_in),
    .q     (crst_s2)
  );

  logic [CW-1:0]      count_s3_q, count_s3_d;
  logic [CW-1:0]      count_sync_q, count_sync_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic               fault_q, fault_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic               stable, accept, legal;
  logic [CW-1:0]      count_inc;

  // A sample is only trusted once two consecutive synchronized values agree.
  always_comb begin
    count_s3_d   = count_s2;
    count_inc    = count_sync_q + CW'(1);
    stable       = (count_s2 == count_s3_q);
    accept       = stable && (count_s3_q != count_sync_q);
    legal        = (count_s3_q == count_inc);
    count_sync_d = count_sync_q;
    step_d       = 1'b0;
    wrap_d       = 1'b0;
    err_d        = 1'b0;
    fault_d      = fault_q;
    state_d      = state_q;

    if (accept) count_sync_d = count_s3_q;

    if (crst_s2) begin
      state_d = ST_WAIT;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (stable) state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (accept) begin
            if (legal) begin
              step_d = 1'b1;
              wrap_d = (count_s3_q == '0);
            end else begin
              err_d   = 1'b1;
              fault_d = 1'b1;
              state_d = ST_FAULT;
            end
          end
        end
        ST_FAULT: begin
          if (accept && !legal) err_d = 1'b1;
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_s3_q   <= '0;
      count_sync_q <= '0;
      step_q       <= 1'b0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
      fault_q      <= 1'b0;
      state_q      <= ST_WAIT;
    end else begin
      count_s3_q   <= count_s3_d;
      count_sync_q <= count_sync_d;
      step_q       <= step_d;
      wrap_q       <= wrap_d;
      err_q        <= err_d;
      fault_q      <= fault_d;
      state_q      <= state_d;
    end
  end

  assign count_sync = count_sync_q;
  assign step       = step_q;
  assign wrap       = wrap_q;
  assign err        = err_q;
  assign fault      = fault_q;

`ifdef ERRCNT_EN
  logic [EW-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of illegal transitions; only the main reset clears it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + EW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed, table-driven bench for count_monitor (CW=3, EW=2).
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] count_in;
  logic       cnt_reset_in;
  logic [2:0] count_sync;
  logic       step, wrap, err, fault;
  logic [1:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  count_monitor #(.CW(3), .EW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .count_in     (count_in),
    .cnt_reset_in (cnt_reset_in),
    .count_sync   (count_sync),
    .step         (step),
    .wrap         (wrap),
    .err          (err),
    .fault        (fault),
    .err_cnt      (err_cnt)
  );

  typedef struct {
    logic       rst;
    logic       crst;
    logic [2:0] cnt;
    int         hold;
    logic [2:0] e_cs;
    int         e_step;
    int         e_wrap;
    int         e_err;
    logic       e_fault;
    int         e_ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic crst, logic [2:0] cnt, int hold,
                              logic [2:0] cs, int st, int wr, int er, logic flt, int ec);
    vec_t v;
    v.rst = rst; v.crst = crst; v.cnt = cnt; v.hold = hold; v.e_cs = cs;
    v.e_step = st; v.e_wrap = wr; v.e_err = er; v.e_fault = flt; v.e_ec = ec;
    return v;
  endfunction

  function automatic int ecx(int v);
`ifdef ERRCNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_excl(string name);
    n_tests++;
    if ((err && (step || wrap)) || (wrap && !step)) begin
      n_fail++;
      $display("FAIL %s: illegal pulse mix step=%0b wrap=%0b err=%0b", name, step, wrap, err);
    end
  endtask

  initial begin
    int ns, nw, ne;

    // idle, full 0..7->0 walk, glitch filter, TRACK error, FAULT behaviour
    tbl.push_back(mk(0, 0, 3'd0, 2, 3'd0, 0, 0, 0, 0, 0));
    for (int i = 1; i < 8; i++) tbl.push_back(mk(0, 0, 3'(i), 4, 3'(i), 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 4, 3'd0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd1, 4, 3'd1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd2, 4, 3'd2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd3, 4, 3'd3, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd2, 1, 3'd3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd4, 4, 3'd4, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd5, 4, 3'd5, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd2, 4, 3'd2, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 3'd3, 4, 3'd3, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 3'd6, 4, 3'd6, 0, 0, 1, 1, 2));
    // cnt_reset with simultaneous illegal 6->0 accept: no err, fault cleared
    tbl.push_back(mk(0, 1, 3'd0, 4, 3'd0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 3'd0, 4, 3'd0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 3'd1, 4, 3'd1, 1, 0, 0, 0, 2));
    // main reset mid-run, then saturation: five illegal jumps separated by cnt_reset
    tbl.push_back(mk(1, 0, 3'd0, 2, 3'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 2, 3'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd1, 4, 3'd1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd4, 4, 3'd4, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 3'd4, 4, 3'd4, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 3'd4, 4, 3'd4, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 3'd7, 4, 3'd7, 0, 0, 1, 1, 2));
    tbl.push_back(mk(0, 1, 3'd7, 4, 3'd7, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 3'd7, 4, 3'd7, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 3'd2, 4, 3'd2, 0, 0, 1, 1, 3));
    tbl.push_back(mk(0, 1, 3'd2, 4, 3'd2, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 3'd2, 4, 3'd2, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 3'd5, 4, 3'd5, 0, 0, 1, 1, 3));
    tbl.push_back(mk(0, 1, 3'd5, 4, 3'd5, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 3'd5, 4, 3'd5, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 3'd0, 4, 3'd0, 0, 0, 1, 1, 3));
    tbl.push_back(mk(0, 1, 3'd0, 4, 3'd0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 3'd0, 4, 3'd0, 0, 0, 0, 0, 3));

    // power-on reset
    reset = 1'b1; cnt_reset_in = 1'b0; count_in = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_cs",    int'(count_sync), 0);
    check("rst_step",  int'(step),       0);
    check("rst_wrap",  int'(wrap),       0);
    check("rst_err",   int'(err),        0);
    check("rst_fault", int'(fault),      0);
    check("rst_ecnt",  int'(err_cnt),    0);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; cnt_reset_in = tbl[i].crst; count_in = tbl[i].cnt;
      ns = 0; nw = 0; ne = 0;
      for (int k = 0; k < tbl[i].hold; k++) begin
        @(posedge clk);
        @(negedge clk);
        ns += int'(step); nw += int'(wrap); ne += int'(err);
        check_excl($sformatf("v%0d_excl", i));
      end
      check($sformatf("v%0d_cs", i),    int'(count_sync), int'(tbl[i].e_cs));
      check($sformatf("v%0d_step", i),  ns,               tbl[i].e_step);
      check($sformatf("v%0d_wrap", i),  nw,               tbl[i].e_wrap);
      check($sformatf("v%0d_err", i),   ne,               tbl[i].e_err);
      check($sformatf("v%0d_fault", i), int'(fault),      int'(tbl[i].e_fault));
      check($sformatf("v%0d_ecnt", i),  int'(err_cnt),    ecx(tbl[i].e_ec));
    end

    // TRACK at 0: illegal 0->3 whose accept edge coincides with reset
    count_in = 3'd3;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("lat%0d_err", k),  int'(err),  0);
      check($sformatf("lat%0d_step", k), int'(step), 0);
    end
    check("lat_cs_held", int'(count_sync), 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstacc_cs",    int'(count_sync), 0);
    check("rstacc_err",   int'(err),        0);
    check("rstacc_step",  int'(step),       0);
    check("rstacc_fault", int'(fault),      0);
    check("rstacc_ecnt",  int'(err_cnt),    0);
    @(posedge clk);
    @(negedge clk);
    check("rstacc_err2",  int'(err),        0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
